// File: rtl/board_step_ctrl.sv
// Board front end: debounces the step push-button into a single-cycle step pulse,
// counts accepted presses and drives a switch-selected debug byte onto the LEDs.
module board_step_ctrl #(
   parameter int DEB_CYCLES = 1_000_000,
   parameter int CNT_W      = 20
) (
   input  logic        clk_100MHz,
   input  logic        rst,
   input  logic        btn,
   input  logic [2:0]  SW,
   input  logic [7:0]  pc_in,
   input  logic [31:0] instr_in,
   input  logic [31:0] alu_in,
   output logic        step,
   output logic [7:0]  step_cnt,
   output logic [7:0]  LED
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_r;
   logic             btn_s;
   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             step_r;
   logic [7:0]       step_cnt_r;
   logic [7:0]       led_r;
   logic [7:0]       led_nxt_s;

   assign btn_s    = sync_r[1];
   assign step     = step_r;
   assign step_cnt = step_cnt_r;
   assign LED      = led_r;

   // Two-flop synchronizer for the asynchronous button
   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], btn};
      end
   end

   // Debounce FSM; step fires only on the press-accept transition
   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         step_r  <= 1'b0;
      end else begin
         step_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (btn_s) begin
                  state_r <= DB_PRESS;
                  cnt_r   <= '0;
               end
            end
            DB_PRESS: begin
               if (!btn_s) begin
                  state_r <= IDLE;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= HELD;
                  step_r  <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            HELD: begin
               if (!btn_s) begin
                  state_r <= DB_RELEASE;
                  cnt_r   <= '0;
               end
            end
            DB_RELEASE: begin
               if (btn_s) begin
                  state_r <= HELD;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   // Press counter, wraps silently at 256
   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         step_cnt_r <= 8'd0;
      end else if (step_r) begin
         step_cnt_r <= step_cnt_r + 8'd1;
      end else begin
         step_cnt_r <= step_cnt_r;
      end
   end

   // Fully decoded LED source select
   always_comb begin
      led_nxt_s = 8'd0;
      case (SW)
         3'd0:    led_nxt_s = pc_in;
         3'd1:    led_nxt_s = instr_in[7:0];
         3'd2:    led_nxt_s = instr_in[15:8];
         3'd3:    led_nxt_s = instr_in[23:16];
         3'd4:    led_nxt_s = instr_in[31:24];
         3'd5:    led_nxt_s = alu_in[7:0];
         3'd6:    led_nxt_s = alu_in[15:8];
         3'd7:    led_nxt_s = step_cnt_r;
         default: led_nxt_s = 8'd0;
      endcase
   end

   // LED output register
   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         led_r <= 8'd0;
      end else begin
         led_r <= led_nxt_s;
      end
   end

endmodule

// File: tb/tb_board_step_ctrl.sv
// Scoreboard bench for board_step_ctrl with a short debounce window.
module tb_board_step_ctrl;

   localparam int DEB = 4;
   localparam int LAT = DEB + 3;

   logic        clk;
   logic        rst;
   logic        btn;
   logic [2:0]  sw;
   logic [7:0]  pc_in;
   logic [31:0] instr_in;
   logic [31:0] alu_in;
   logic        step;
   logic [7:0]  step_cnt;
   logic [7:0]  led;

   typedef struct {
      int       cyc;
      logic [7:0] val;
   } exp_t;

   exp_t step_q[$];
   exp_t led_q[$];

   int       cyc;
   int       n_cmp;
   int       n_bad;
   logic [7:0] exp_cnt;
   logic       pend;
   logic [7:0] pend_val;

   board_step_ctrl #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
      .clk_100MHz(clk),
      .rst       (rst),
      .btn       (btn),
      .SW        (sw),
      .pc_in     (pc_in),
      .instr_in  (instr_in),
      .alu_in    (alu_in),
      .step      (step),
      .step_cnt  (step_cnt),
      .LED       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp = n_cmp + 1;
      if (act !== expv) begin
         n_bad = n_bad + 1;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, expv);
      end
   endtask

   // Monitor: pops expected step events and LED values as the DUT presents them
   always @(negedge clk) begin
      exp_t e;
      if (pend) begin
         chk("step_cnt_incr", {24'd0, step_cnt}, {24'd0, pend_val});
         pend = 1'b0;
      end
      if (step === 1'b1) begin
         if (step_q.size() == 0) begin
            chk("step_unexpected", 32'd1, 32'd0);
         end else begin
            e = step_q.pop_front();
            chk("step_cycle", cyc, e.cyc);
            chk("step_cnt_at_step", {24'd0, step_cnt}, {24'd0, e.val});
            pend     = 1'b1;
            pend_val = e.val + 8'd1;
         end
      end
      if (led_q.size() > 0 && led_q[0].cyc == cyc) begin
         e = led_q.pop_front();
         chk("led", {24'd0, led}, {24'd0, e.val});
      end
   end

   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Press at the current negedge, hold, release and wait out the release debounce
   task automatic press(input int hold, input int gap, input logic track_led);
      exp_t e;
      btn   = 1'b1;
      e.cyc = cyc + LAT;
      e.val = exp_cnt;
      step_q.push_back(e);
      if (track_led) begin
         exp_t l;
         l.cyc = cyc + LAT + 2;
         l.val = exp_cnt + 8'd1;
         led_q.push_back(l);
      end
      exp_cnt = exp_cnt + 8'd1;
      wait_cyc(hold);
      btn = 1'b0;
      wait_cyc(gap);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] led_exp [0:6];
      exp_t l;
      led_exp[0] = 8'h3C; led_exp[1] = 8'hEF; led_exp[2] = 8'hBE; led_exp[3] = 8'hAD;
      led_exp[4] = 8'hDE; led_exp[5] = 8'h34; led_exp[6] = 8'h12;
      cyc = 0; n_cmp = 0; n_bad = 0; exp_cnt = 8'd0; pend = 1'b0; pend_val = 8'd0;
      rst = 1'b0; btn = 1'b1; sw = 3'd7;
      pc_in = 8'h3C; instr_in = 32'hDEADBEEF; alu_in = 32'h00001234;

      // Reset held with button pressed
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_step", {31'd0, step}, 32'd0);
         chk("rst_step_cnt", {24'd0, step_cnt}, 32'd0);
         chk("rst_led", {24'd0, led}, 32'd0);
      end
      rst = 1'b1;
      press(10, 12, 1'b1);
      chk("after_first_cnt", {24'd0, step_cnt}, 32'd1);
      chk("after_first_led", {24'd0, led}, 32'd1);

      // Mid-debounce reset: DB_PRESS with cnt=2 after 5 edges
      btn = 1'b1;
      wait_cyc(5);
      rst = 1'b0;
      #1;
      chk("midrst_step", {31'd0, step}, 32'd0);
      chk("midrst_cnt", {24'd0, step_cnt}, 32'd0);
      chk("midrst_led", {24'd0, led}, 32'd0);
      exp_cnt = 8'd0;
      wait_cyc(3);
      btn = 1'b0;
      rst = 1'b1;
      wait_cyc(10);
      chk("post_midrst_cnt", {24'd0, step_cnt}, 32'd0);

      // Clean press, long hold and long idle
      press(20, 20, 1'b0);
      chk("clean_cnt", {24'd0, step_cnt}, 32'd1);

      // Glitch of 3 cycles
      btn = 1'b1;
      wait_cyc(3);
      btn = 1'b0;
      wait_cyc(15);
      chk("glitch_cnt", {24'd0, step_cnt}, 32'd1);

      // Press with bouncing release
      press(20, 0, 1'b0);
      btn = 1'b1; wait_cyc(1);
      btn = 1'b0; wait_cyc(1);
      btn = 1'b1; wait_cyc(1);
      btn = 1'b0; wait_cyc(20);
      chk("bounce_cnt", {24'd0, step_cnt}, 32'd2);

      // LED mux sweep
      for (int s = 0; s < 7; s++) begin
         sw    = 3'(s);
         l.cyc = cyc + 1;
         l.val = led_exp[s];
         led_q.push_back(l);
         @(negedge clk);
      end
      sw = 3'd7;
      wait_cyc(2);
      chk("sw7_led", {24'd0, led}, 32'd2);

      // 256 presses wrap the counter
      rst = 1'b0;
      wait_cyc(2);
      rst = 1'b1;
      exp_cnt = 8'd0;
      wait_cyc(2);
      for (int p = 0; p < 256; p++) press(9, 9, 1'b1);
      wait_cyc(4);
      chk("wrap_cnt", {24'd0, step_cnt}, 32'd0);
      chk("wrap_led", {24'd0, led}, 32'd0);
      chk("step_q_empty", step_q.size(), 32'd0);
      chk("led_q_empty", led_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
